// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters, post-reset invalidate sweep, 1-cycle lookup. Ports: clk, rst, fetchValid/fetchPc -> branchPredict, ready, updateValid/updatePc/updateTaken/updateTarget. Optional BTB_UPDATE_FORWARD_EN forwards a same-index update into the lookup.
package btb_pkg;
  localparam int ADDR_WIDTH = 32;
  typedef logic [ADDR_WIDTH-1:0] PC;
  typedef struct packed {
    logic isNextPcPredicted;
    logic isBranchTakenPredicted;
    PC    predictedNextPc;
  } BranchPredict;
endpackage

module branch_target_buffer
  import btb_pkg::*;
#(
  parameter  int ENTRY_NUM   = 64,
  localparam int INDEX_WIDTH = $clog2(ENTRY_NUM),
  localparam int TAG_WIDTH   = ADDR_WIDTH - 2 - INDEX_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetchValid,
  input  PC            fetchPc,
  output BranchPredict branchPredict,
  output logic         ready,
  input  logic         updateValid,
  input  PC            updatePc,
  input  logic         updateTaken,
  input  PC            updateTarget
);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(ENTRY_NUM - 1);
  logic [0:0] state;
  logic [INDEX_WIDTH-1:0] sweepIdx;
  logic [ENTRY_NUM-1:0] validArr;
  logic [TAG_WIDTH-1:0] tagArr [ENTRY_NUM];
  PC targetArr [ENTRY_NUM];
  logic [1:0] cntArr [ENTRY_NUM];
  logic isReady, updHit, updWrite, rdValid, lookupTaken, unusedPcBits;
  logic [INDEX_WIDTH-1:0] fetchIdx, updIdx;
  logic [TAG_WIDTH-1:0] fetchTag, updTag, rdTag;
  logic [1:0] curCnt, newCnt, rdCnt;
  PC newTarget, rdTarget;
  BranchPredict nextPred;
  assign isReady = state == READY;
  assign ready = isReady;
  assign fetchIdx = fetchPc[2 +: INDEX_WIDTH];
  assign fetchTag = fetchPc[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign updIdx = updatePc[2 +: INDEX_WIDTH];
  assign updTag = updatePc[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign unusedPcBits = ^updatePc[1:0];
  assign curCnt = cntArr[updIdx];
  assign updHit = validArr[updIdx] && tagArr[updIdx] == updTag;
  // a not-taken miss has nothing worth remembering, so it writes nothing
  assign updWrite = isReady && updateValid && (updHit || updateTaken);
  assign newCnt = !updHit ? 2'd2
                : updateTaken ? (curCnt == 2'd3 ? 2'd3 : curCnt + 2'd1)
                : (curCnt == 2'd0 ? 2'd0 : curCnt - 2'd1);
  assign newTarget = (updHit && !updateTaken) ? targetArr[updIdx] : updateTarget;
`ifdef BTB_UPDATE_FORWARD_EN
  logic fwd;
  assign fwd = updWrite && updIdx == fetchIdx;
  assign rdValid = fwd || validArr[fetchIdx];
  assign rdTag = fwd ? updTag : tagArr[fetchIdx];
  assign rdTarget = fwd ? newTarget : targetArr[fetchIdx];
  assign rdCnt = fwd ? newCnt : cntArr[fetchIdx];
`else
  assign rdValid = validArr[fetchIdx];
  assign rdTag = tagArr[fetchIdx];
  assign rdTarget = targetArr[fetchIdx];
  assign rdCnt = cntArr[fetchIdx];
`endif
  assign lookupTaken = fetchValid && rdValid && rdTag == fetchTag && rdCnt[1];
  assign nextPred = '{lookupTaken, lookupTaken, lookupTaken ? rdTarget : fetchPc + PC'(4)};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      sweepIdx <= '0;
      branchPredict <= '0;
    end else begin
      branchPredict <= isReady ? nextPred : '0;
      if (!isReady) begin
        sweepIdx <= sweepIdx + 1'b1;
        if (sweepIdx == LAST_IDX) state <= READY;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!isReady) validArr[sweepIdx] <= 1'b0;
      else if (updWrite) begin
        validArr[updIdx] <= 1'b1;
        tagArr[updIdx] <= updTag;
        targetArr[updIdx] <= newTarget;
        cntArr[updIdx] <= newCnt;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed checks of init sweep, lookup, counter training, aliasing, same-cycle forwarding and reset restart.
module tb_branch_target_buffer;
  import btb_pkg::*;
  logic clk = 1'b0;
  logic rst, fetchValid, updateValid, updateTaken, ready;
  PC fetchPc, updatePc, updateTarget;
  BranchPredict branchPredict;
  int errors = 0;
  int checks = 0;

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .fetchValid(fetchValid), .fetchPc(fetchPc),
    .branchPredict(branchPredict), .ready(ready), .updateValid(updateValid),
    .updatePc(updatePc), .updateTaken(updateTaken), .updateTarget(updateTarget)
  );

  always #5 clk = ~clk;

  function automatic BranchPredict bp(input logic t, input PC nxt);
    return '{t, t, nxt};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chkPred(input string tag, input BranchPredict exp);
    checks++;
    assert (branchPredict === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, branchPredict, exp);
    end
  endtask

  task automatic chkReady(input string tag, input logic exp);
    checks++;
    assert (ready === exp) else begin
      errors++;
      $error("FAIL %s ready got=%b exp=%b", tag, ready, exp);
    end
  endtask

  task automatic upd(input PC pc, input logic taken, input PC tgt);
    updateValid = 1'b1; updatePc = pc; updateTaken = taken; updateTarget = tgt;
    fetchValid = 1'b0;
    tick();
    updateValid = 1'b0;
  endtask

  task automatic look(input string tag, input PC pc, input BranchPredict exp);
    fetchValid = 1'b1; fetchPc = pc;
    tick();
    fetchValid = 1'b0;
    chkPred(tag, exp);
  endtask

  task automatic sweep(input string tag);
    for (int i = 1; i <= 64; i++) begin
      tick();
      chkReady(tag, i == 64);
      chkPred(tag, '0);
    end
  endtask

  initial begin
    rst = 1'b1; fetchValid = 1'b0; fetchPc = '0;
    updateValid = 1'b0; updatePc = '0; updateTaken = 1'b0; updateTarget = '0;
    @(negedge clk);
    tick();
    chkReady("resetReady", 1'b0);
    chkPred("resetPred", '0);
    rst = 1'b0;
    fetchValid = 1'b1; fetchPc = 32'h100;
    updateValid = 1'b1; updatePc = 32'h100; updateTaken = 1'b1; updateTarget = 32'h400;
    sweep("init");
    fetchValid = 1'b0; updateValid = 1'b0;
    look("initUpdIgnored", 32'h100, bp(1'b0, 32'h104));
    upd(32'h100, 1'b1, 32'h400);
    look("allocHit", 32'h100, bp(1'b1, 32'h400));
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look("trainNt", 32'h100, bp(1'b0, 32'h104));
    upd(32'h100, 1'b1, 32'h480);
    look("satLow", 32'h100, bp(1'b0, 32'h104));
    upd(32'h100, 1'b1, 32'h480);
    upd(32'h100, 1'b1, 32'h480);
    upd(32'h100, 1'b1, 32'h480);
    look("trainT", 32'h100, bp(1'b1, 32'h480));
    upd(32'h100, 1'b0, 32'h999);
    look("satHighKeepTgt", 32'h100, bp(1'b1, 32'h480));
    upd(32'h100, 1'b0, 32'h0);
    look("weakNt", 32'h100, bp(1'b0, 32'h104));
    upd(32'h200, 1'b1, 32'h900);
    look("aliasEvict", 32'h100, bp(1'b0, 32'h104));
    look("aliasNew", 32'h200, bp(1'b1, 32'h900));
    upd(32'h300, 1'b0, 32'h0);
    look("ntMissNoAlloc", 32'h200, bp(1'b1, 32'h900));
    upd(32'h104, 1'b0, 32'h0);
    look("ntMissEmpty", 32'h104, bp(1'b0, 32'h108));
    look("pcWrap", 32'hFFFF_FFFC, bp(1'b0, 32'h0));
    fetchPc = 32'h200;
    tick();
    chkPred("fetchInvalid", bp(1'b0, 32'h204));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chkReady("midSweep", 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep("restart");
    look("missAfterReset", 32'h200, bp(1'b0, 32'h204));
    updateValid = 1'b1; updatePc = 32'h100; updateTaken = 1'b1; updateTarget = 32'h800;
    fetchValid = 1'b1; fetchPc = 32'h100;
    tick();
    updateValid = 1'b0; fetchValid = 1'b0;
`ifdef BTB_UPDATE_FORWARD_EN
    chkPred("sameCycle", bp(1'b1, 32'h800));
`else
    chkPred("sameCycle", bp(1'b0, 32'h104));
`endif
    look("afterSameCycle", 32'h100, bp(1'b1, 32'h800));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
